i2s_loopback_core: RTL and testbench
====================================

I2S_LOOPBACK_CORE -- requirements
Module: i2s_loopback_core

Interface
REQ-001 Parameter DATA_W, default 24, audio sample width in bits; the block SHALL support only the value 24.
REQ-002 mck  in  1  master clock; the only clock; all flops SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset, sampled on rising mck.
REQ-004 tx_data  in  24  parallel sample to transmit; the same value SHALL be sent on both channels.
REQ-005 sdin  in  1  serial I2S data input.
REQ-006 sck  out  1  system clock, mck/2.
REQ-007 bck  out  1  bit clock, mck/8.
REQ-008 lrck  out  1  word-select clock, mck/512; 0 = left, 1 = right.
REQ-009 sdout  out  1  serial I2S data output.
REQ-010 rx_data  out  24  last fully received sample.
REQ-011 rx_valid  out  1  one-mck pulse when rx_data updates.
REQ-012 rx_right  out  1  channel of the current rx_data; 1 = right.

Function
REQ-013 A free-running 9-bit counter cnt SHALL increment by 1 every mck and wrap from 511 to 0.
REQ-014 sck SHALL equal cnt[0], bck SHALL equal cnt[2], and lrck SHALL equal cnt[8], all registered.
REQ-015 Slot index SHALL be cnt[7:3] (0..31); each channel SHALL hold 32 bck periods.
REQ-016 The bck falling event SHALL occur when cnt[2:0] wraps from 7 to 0.
REQ-017 The bck rising event SHALL occur when cnt[2:0] goes from 3 to 4.
REQ-018 On each lrck transition (cnt[7:0] becomes 0), tx_data SHALL be latched into a 24-bit transmit register.
REQ-019 Changes to tx_data at other times SHALL take effect only at the next lrck transition.
REQ-020 sdout SHALL be registered and change only on bck falling events.
REQ-021 Standard I2S framing: in slot k = 1..24, sdout SHALL present latched bit [24-k] (MSB first, one bck after the lrck edge).
REQ-022 In slot 0 and slots 25..31, sdout SHALL be 0.
REQ-023 The receiver SHALL sample sdin on bck rising events in slots 1..24 and shift it in MSB first.
REQ-024 The receiver SHALL ignore sdin in all other slots.
REQ-025 On the slot-24 sample, the assembled 24 bits SHALL load into rx_data on the same mck edge as that sample.
REQ-026 On that same edge, rx_valid SHALL pulse for exactly one mck and rx_right SHALL take the lrck level of that slot.
REQ-027 rx_data, rx_right and rx_valid SHALL remain unchanged except on that load.
REQ-028 With sdout looped to sdin, rx_data SHALL update 196 mck cycles after the lrck edge that latched the sample (slot 24, cnt[7:0] = 196).
REQ-029 Reception SHALL rely only on cnt; no bck/lrck-derived clocks or asynchronous logic are permitted.

Reset
REQ-030 While reset = 0 at a rising mck edge, the block SHALL set cnt = 0 and sck = bck = lrck = 0.
REQ-031 While reset = 0 at a rising mck edge, the block SHALL set sdout = 0, the transmit register = 0 and the receive shift register = 0.
REQ-032 While reset = 0 at a rising mck edge, the block SHALL set rx_data = 0, rx_valid = 0 and rx_right = 0.
REQ-033 Asserting reset mid-frame SHALL abort the partial frame, with no rx_valid for it.
REQ-034 After reset is released, counting SHALL restart at cnt = 0 (left channel, slot 0) on the next mck edge.
REQ-035 The first latch of tx_data after reset SHALL occur at the first lrck edge following release.

Verification
REQ-036 Clock ratios: after reset release, count mck edges -> sck toggles every 1, bck every 4, lrck every 256 mck cycles.
REQ-037 Loopback: tx_data = 0x888888, sdout wired to sdin -> each channel gives rx_data = 0x888888 with one rx_valid pulse; rx_right alternates 0,1.
REQ-038 Serial format: tx_data = 0xF0F0F0 -> sdout = 0 in slot 0; slots 1..24 carry 1111 0000 1111 0000 1111 0000; sdout = 0 in slots 25..31.
REQ-039 Mid-channel update: change tx_data from 0xF0F0F0 to 0x1F3AF0 in slot 10 -> current channel receives 0xF0F0F0; next channel receives 0x1F3AF0.
REQ-040 Sequence 0x123456 then 0x612345, each held 512 mck -> rx_data shows each value for both channels, 196 mck after its latching edge.
REQ-041 Reset mid-frame at slot 12 -> all outputs 0 next edge, no rx_valid for the aborted frame; clean reception resumes from the first full frame.

Source files
------------

// File: rtl/i2s_loopback_core_if.sv
// Parallel sample and serial I2S signals of the loopback core, bundled so the
// core and its environment see one port with a direction per side.
interface i2s_loopback_core_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] tx_data;
   logic              sdin;
   logic              sck;
   logic              bck;
   logic              lrck;
   logic              sdout;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_right;

   // Core side: generates the clocks, transmits and receives.
   modport master (
      input  tx_data, sdin,
      output sck, bck, lrck, sdout, rx_data, rx_valid, rx_right
   );

   // Environment side: supplies samples and serial input, observes the rest.
   modport slave (
      output tx_data, sdin,
      input  sck, bck, lrck, sdout, rx_data, rx_valid, rx_right
   );
endinterface

// File: rtl/i2s_loopback_core.sv
// I2S master transmitter plus receiver, both timed from one free-running
// 9-bit mck counter: sck = cnt[0], bck = cnt[2], lrck = cnt[8], slot = cnt[7:3].
// The transmitter sends the latched sample MSB first in slots 1..24 of each
// channel; the receiver samples sdin mid-slot and publishes the word in slot 24.
// Only DATA_W = 24 is supported (the word must fit inside the 32-slot channel).
module i2s_loopback_core #(
   parameter int DATA_W = 24
) (
   input logic                 mck,
   input logic                 reset,
   i2s_loopback_core_if.master bus
);
   localparam logic [4:0] LAST_SLOT = 5'(DATA_W);

   logic [8:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              sdout_q, sdout_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_right_q, rx_right_d;

   logic       bck_fall;   // this edge takes cnt[2:0] from 7 to 0
   logic       bck_rise;   // this edge takes cnt[2:0] from 3 to 4
   logic [4:0] slot_now;   // slot the counter is in before this edge
   logic [4:0] slot_next;  // slot the counter enters on this edge

   assign bck_fall  = (cnt_q[2:0] == 3'd7);
   assign bck_rise  = (cnt_q[2:0] == 3'd3);
   assign slot_now  = cnt_q[7:3];
   assign slot_next = cnt_d[7:3];

   // Next-state logic for the counter, transmit shifter and receiver.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
      cnt_d      = cnt_q + 9'd1;
      tx_d       = tx_q;
      sdout_d    = sdout_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_right_d = rx_right_q;

      // Transmit side: sdout only moves on bck falling events. Entering slot 0
      // is the lrck edge, where the new sample is captured and the line idles.
      if (bck_fall) begin
         if (slot_next == 5'd0) begin
            tx_d    = bus.tx_data;
            sdout_d = 1'b0;
         end else if (slot_next <= LAST_SLOT) begin
            sdout_d = tx_q[DATA_W-1];
            tx_d    = {tx_q[DATA_W-2:0], 1'b0};
         end else begin
            sdout_d = 1'b0;
         end
      end

      // Receive side: sample mid-slot in the data slots, publish on the last one.
      if (bck_rise && (slot_now >= 5'd1) && (slot_now <= LAST_SLOT)) begin
         rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.sdin};
         if (slot_now == LAST_SLOT) begin
            rx_data_d  = {rx_sh_q[DATA_W-2:0], bus.sdin};
            rx_valid_d = 1'b1;
            rx_right_d = cnt_q[8];
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge mck) begin
      // NOTE: all state uses non-blocking assignment so every flop sees pre-edge values.
      if (!reset) begin
         // NOTE: the shift registers are cleared too, so an aborted frame leaves no residue.
         cnt_q      <= '0;
         tx_q       <= '0;
         sdout_q    <= 1'b0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_right_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         tx_q       <= tx_d;
         sdout_q    <= sdout_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_right_q <= rx_right_d;
      end
   end

   // The derived clocks are counter flop bits, so they are glitch-free.
   assign bus.sck      = cnt_q[0];
   assign bus.bck      = cnt_q[2];
   assign bus.lrck     = cnt_q[8];
   assign bus.sdout    = sdout_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_right = rx_right_q;
endmodule

// File: tb/tb_i2s_loopback_core.sv
// Self-checking bench for i2s_loopback_core with sdout looped to sdin.
// A model counter predicts clock phases; every lrck edge pushes the sample
// expected back 196 mck later onto a scoreboard popped on rx_valid.
module tb_i2s_loopback_core;
   logic mck = 1'b0;
   logic reset;

   i2s_loopback_core_if #(.DATA_W(24)) bus ();

   i2s_loopback_core #(.DATA_W(24)) dut (
      .mck   (mck),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.sdin = bus.sdout;

   always #5 mck = ~mck;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int hold_err = 0;
   logic [8:0] mcnt = '0;

   typedef struct {
      logic [23:0] data;
      logic        right;
      int          due;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [23:0] tx;
      logic [31:0] slots;  // bit 31 = slot 0 ... bit 0 = slot 31
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   // Reference counter and scoreboard producer, evaluated on each rising mck.
   always @(posedge mck) begin
      cyc++;
      if (!reset) begin
         mcnt = '0;
         sb_q.delete();
         // the frame starting right after release carries the cleared transmit register
         sb_q.push_back('{data: 24'h0, right: 1'b0, due: cyc + 196});
      end else begin
         mcnt = mcnt + 9'd1;
         if (mcnt[7:0] == 8'd0)
            sb_q.push_back('{data: bus.tx_data, right: mcnt[8], due: cyc + 196});
      end
   end

   // Scoreboard consumer and hold check, away from the active edge.
   logic [23:0] prev_data  = '0;
   logic        prev_right = 1'b0;
   always @(negedge mck) begin
      exp_t e;
      if (bus.rx_valid) begin
         if (sb_q.size() == 0) begin
            check("rx_unexpected", 32'(bus.rx_valid), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("rx_data",  32'(bus.rx_data),  32'(e.data));
            check("rx_right", 32'(bus.rx_right), 32'(e.right));
            check("rx_time",  32'(cyc),          32'(e.due));
         end
      end else if (reset && ((bus.rx_data !== prev_data) || (bus.rx_right !== prev_right))) begin
         hold_err++;
      end
      prev_data  = bus.rx_data;
      prev_right = bus.rx_right;
   end

   task automatic wait_cnt(input logic [7:0] target);
      int n = 0;
      while ((mcnt[7:0] != target) && (n < 600)) begin
         @(negedge mck);
         n++;
      end
      if (mcnt[7:0] != target) check("wait_cnt_timeout", 32'(mcnt[7:0]), 32'(target));
   endtask

   task automatic wait_rx(output logic [23:0] d, output logic r);
      int n = 0;
      @(negedge mck);
      while (!bus.rx_valid && (n < 600)) begin
         @(negedge mck);
         n++;
      end
      if (!bus.rx_valid) check("wait_rx_timeout", 32'd0, 32'd1);
      d = bus.rx_data;
      r = bus.rx_right;
   endtask

   // Records sdout at mid-slot for one channel and counts changes inside a slot.
   task automatic capture_frame(output logic [31:0] bits, output int unstable);
      bits     = '0;
      unstable = 0;
      wait_cnt(8'd4);
      for (int s = 0; s < 32; s++) begin
         bits[31-s] = bus.sdout;
         for (int k = 1; k <= 8; k++) begin
            @(negedge mck);
            if ((k <= 3) && (bus.sdout !== bits[31-s])) unstable++;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sck"},      32'(bus.sck),      32'd0);
      check({tag, "_bck"},      32'(bus.bck),      32'd0);
      check({tag, "_lrck"},     32'(bus.lrck),     32'd0);
      check({tag, "_sdout"},    32'(bus.sdout),    32'd0);
      check({tag, "_rx_data"},  32'(bus.rx_data),  32'd0);
      check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
      check({tag, "_rx_right"}, 32'(bus.rx_right), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bits;
      int          unst;
      logic [23:0] d;
      logic        r;
      int          ph_err, sck_t, bck_t, lrck_t, missing;
      logic        p_sck, p_bck, p_lrck;

      // slot image = {0, sample, 7'b0}
      vecs[0] = '{tx: 24'hF0F0F0, slots: 32'h7878_7800};
      vecs[1] = '{tx: 24'h888888, slots: 32'h4444_4400};
      vecs[2] = '{tx: 24'h123456, slots: 32'h091A_2B00};
      vecs[3] = '{tx: 24'h612345, slots: 32'h3091_A280};

      // Reset state; a nonzero sample must not appear before the first lrck edge.
      reset       = 1'b0;
      bus.tx_data = 24'hABCDEF;
      repeat (4) @(negedge mck);
      check_all_zero("reset");

      // Clock ratios and phases over one full 512-cycle counter period.
      reset  = 1'b1;
      ph_err = 0; sck_t = 0; bck_t = 0; lrck_t = 0;
      p_sck  = bus.sck; p_bck = bus.bck; p_lrck = bus.lrck;
      for (int i = 0; i < 512; i++) begin
         @(negedge mck);
         if ((bus.sck !== mcnt[0]) || (bus.bck !== mcnt[2]) || (bus.lrck !== mcnt[8])) ph_err++;
         if (bus.sck  !== p_sck)  sck_t++;
         if (bus.bck  !== p_bck)  bck_t++;
         if (bus.lrck !== p_lrck) lrck_t++;
         p_sck = bus.sck; p_bck = bus.bck; p_lrck = bus.lrck;
      end
      check("clk_phase",    32'(ph_err), 32'd0);
      check("sck_toggles",  32'(sck_t),  32'd512);
      check("bck_toggles",  32'(bck_t),  32'd128);
      check("lrck_toggles", 32'(lrck_t), 32'd2);

      // Serial format for each table entry on both channels; loopback via scoreboard.
      for (int i = 0; i < 4; i++) begin
         bus.tx_data = vecs[i].tx;
         wait_cnt(8'd128);
         for (int ch = 0; ch < 2; ch++) begin
            capture_frame(bits, unst);
            check($sformatf("slots[%0d].ch%0d", i, ch), bits, vecs[i].slots);
            check($sformatf("stable[%0d].ch%0d", i, ch), 32'(unst), 32'd0);
         end
      end

      // Mid-channel update in slot 10: current channel keeps the old sample.
      bus.tx_data = 24'hF0F0F0;
      wait_cnt(8'd128);
      wait_cnt(8'd82);
      bus.tx_data = 24'h1F3AF0;
      wait_rx(d, r);
      check("midchan_current", 32'(d), 32'h00F0_F0F0);
      wait_rx(d, r);
      check("midchan_next", 32'(d), 32'h001F_3AF0);

      // Reset in slot 12 aborts the frame; reception restarts cleanly.
      bus.tx_data = 24'hA5C3E1;
      wait_cnt(8'd128);
      wait_cnt(8'd64);
      wait_cnt(8'd200);
      check("pre_reset_rx", 32'(bus.rx_data), 32'h00A5_C3E1);
      wait_cnt(8'd98);
      reset = 1'b0;
      @(negedge mck);
      check_all_zero("midreset");
      @(negedge mck);
      reset = 1'b1;
      wait_rx(d, r);
      check("post_reset_first",  32'(d), 32'd0);
      check("post_reset_first_ch", 32'(r), 32'd0);
      wait_rx(d, r);
      check("post_reset_second", 32'(d), 32'h00A5_C3E1);
      check("post_reset_second_ch", 32'(r), 32'd1);

      // Drain: nothing past its due time may remain unmatched.
      repeat (600) @(negedge mck);
      missing = 0;
      foreach (sb_q[i]) if (sb_q[i].due <= cyc) missing++;
      check("sb_missing", 32'(missing), 32'd0);
      check("rx_hold", 32'(hold_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
